bcd_timer_display: RTL

- Six-digit BCD stopwatch/counter that drives the six active-low 7-segment displays (hex0..hex5) and one status LED inside Topo.
- Sits between the board inputs (one key for start/stop, one key for clear, one switch for direction) and the display pins.
- Synchronises and edge-detects the keys, prescales clock_50 to a count tick, runs a run/pause state machine, and encodes each digit to segments.

---
 rtl/bcd_timer_display.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_timer_display.sv
// bcd_timer_display: six-digit BCD stopwatch/counter that drives six active-low
// 7-segment displays and a run LED.
//
// Ports:
//   clock_50      system clock (50 MHz)
//   reset         asynchronous, active-high reset
//   start_stop_n  active-low key; each press toggles run/pause
//   clear_n       active-low key; each press clears the count and stops
//   up_down       count direction, 1 = up, 0 = down; sampled on each tick
//   running       high while in RUN (registered)
//   tick          one-cycle pulse on each count step
//   hex0..hex5    active-low segments {g,f,e,d,c,b,a}; hex0 = least significant
//
// Parameter TICK_DIV: clock_50 cycles per count tick (2..2^26).
// Optional macro LEADING_ZERO_BLANK_EN: when defined, hex5..hex1 are blanked
// while that digit and every more-significant digit are zero.
module bcd_timer_display #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       start_stop_n,
  input  logic       clear_n,
  input  logic       up_down,
  output logic       running,
  output logic       tick,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam int NUM_DIGITS = 6;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                          state;
  logic   [PW-1:0]                 presc;
  logic   [NUM_DIGITS-1:0][3:0]    digits;
  logic   [NUM_DIGITS-1:0][3:0]    digits_nxt;
  logic   [NUM_DIGITS-1:0]         blank;
  logic   [NUM_DIGITS-1:0][6:0]    seg;
  logic   [1:0]                    keys_n;
  logic   [1:0]                    press;
  logic                            ss_p;
  logic                            clr_p;

  // Key conditioning: key_pipe[1:0] is the 2-FF synchroniser, key_pipe[2]
  // holds the previous synchronised level. The press pulse is registered so it
  // is active 3 edges after the pin falls. Everything resets to the released
  // level so no press appears when reset deasserts.
  assign keys_n = {clear_n, start_stop_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [2:0] key_pipe;
    logic       press_q;
    always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
        key_pipe <= '1;
        press_q  <= 1'b0;
      end else begin
        key_pipe <= {key_pipe[1:0], keys_n[k]};
        press_q  <= key_pipe[2] & ~key_pipe[1];
      end
    end
    assign press[k] = press_q;
  end

  assign ss_p  = press[0];
  assign clr_p = press[1];

  // Run/pause state machine; clear wins over start_stop in the same cycle.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clr_p) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (ss_p) begin
      case (state)
        IDLE:    begin state <= RUN;   running <= 1'b1; end
        RUN:     begin state <= PAUSE; running <= 1'b0; end
        PAUSE:   begin state <= RUN;   running <= 1'b1; end
        default: begin state <= IDLE;  running <= 1'b0; end
      endcase
    end
  end

  // Prescaler advances only in RUN and holds in PAUSE so the tick phase
  // survives a pause/resume.
  assign tick = (state == RUN) && (presc == PRE_MAX);

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset)                       presc <= '0;
    else if (clr_p || state == IDLE) presc <= '0;
    else if (state == RUN)           presc <= tick ? '0 : presc + 1'b1;
  end

  // BCD ripple: each digit moves only while every lower digit wraps.
  always_comb begin
    logic carry;
    digits_nxt = digits;
    carry      = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (up_down) begin
          if (digits[i] >= 4'd9) digits_nxt[i] = 4'd0;
          else begin
            digits_nxt[i] = digits[i] + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd0 || digits[i] > 4'd9) digits_nxt[i] = 4'd9;
          else begin
            digits_nxt[i] = digits[i] - 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
  end

  // A tick in the same cycle as a clear pulse is dropped.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset)      digits <= '0;
    else if (clr_p) digits <= '0;
    else if (tick)  digits <= digits_nxt;
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (digits[i] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  // Per-digit segment encoder, combinational from the registered digits.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
    logic [6:0] seg_l;
    always_comb begin
      seg_l = 7'b1111111;
      if (!blank[i]) begin
        case (digits[i])
          4'd0:    seg_l = 7'b1000000;
          4'd1:    seg_l = 7'b1111001;
          4'd2:    seg_l = 7'b0100100;
          4'd3:    seg_l = 7'b0110000;
          4'd4:    seg_l = 7'b0011001;
          4'd5:    seg_l = 7'b0010010;
          4'd6:    seg_l = 7'b0000010;
          4'd7:    seg_l = 7'b1111000;
          4'd8:    seg_l = 7'b0000000;
          4'd9:    seg_l = 7'b0010000;
          default: seg_l = 7'b1111111;
        endcase
      end
    end
    assign seg[i] = seg_l;
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];

endmodule
